// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Control bundle between the multicycle sequencer and the
//               accumulator-processor datapath (PC block, IR, memory port,
//               accumulator, ALU).
//               master : the sequencer (drives controls, sees Opcode/MemReady)
//               slave  : the datapath side (drives Opcode/MemReady)
//               Signals:
//                 Opcode[3:0]  IR[15:12], valid from DECODE onward
//                 MemReady     memory completion strobe
//                 PCWrite, Branch, bneOrbeq, PCSrc[1:0]  PC block controls
//                 IRWrite, MemRead, MemWrite             IR / memory controls
//                 AccWrite, AccSrc, ALUOp[2:0]           accumulator / ALU
//                 Halted, BusError, IllegalOp, State[3:0] status / debug
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if;
    logic [3:0] Opcode;
    logic       MemReady;
    logic       PCWrite;
    logic       Branch;
    logic       bneOrbeq;
    logic [1:0] PCSrc;
    logic       IRWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       AccWrite;
    logic       AccSrc;
    logic [2:0] ALUOp;
    logic       Halted;
    logic       BusError;
    logic       IllegalOp;
    logic [3:0] State;

    modport master (
        input  Opcode, MemReady,
        output PCWrite, Branch, bneOrbeq, PCSrc, IRWrite, MemRead, MemWrite,
               AccWrite, AccSrc, ALUOp, Halted, BusError, IllegalOp, State
    );

    modport slave (
        output Opcode, MemReady,
        input  PCWrite, Branch, bneOrbeq, PCSrc, IRWrite, MemRead, MemWrite,
               AccWrite, AccSrc, ALUOp, Halted, BusError, IllegalOp, State
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Multicycle fetch/decode/execute control FSM for the 16-bit
//               accumulator processor. Watches the memory handshake with a
//               wait counter, faults after WAIT_LIMIT consecutive unanswered
//               request cycles, and halts on the HALT opcode.
//               Ports:
//                 CLK    - system clock, rising edge
//                 reset  - synchronous, active-high
//                 bus    - pc_sequencer_if.master control bundle
//               Parameters:
//                 WAIT_LIMIT - max consecutive wait cycles (1..255)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int WAIT_LIMIT = 15
) (
    input  wire logic       CLK,
    input  wire logic       reset,
    pc_sequencer_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_MEM_RD = 4'd3,
        S_WB_ACC = 4'd4,
        S_MEM_WR = 4'd5,
        S_BRANCH = 4'd6,
        S_JUMP   = 4'd7,
        S_HALT   = 4'd8,
        S_FAULT  = 4'd9
    } state_t;

    // Counter value during the last permitted wait cycle.
    localparam logic [7:0] c_LIMIT_M1 = 8'(WAIT_LIMIT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_wait_cnt;
    logic       w_waiting;
    logic       w_timeout;

    assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                        (r_state == S_MEM_WR)) && !bus.MemReady;
    // MemReady has priority: w_waiting is already false when it arrives.
    assign w_timeout = w_waiting && (r_wait_cnt == c_LIMIT_M1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = bus.MemReady ? S_DECODE :
                               (w_timeout ? S_FAULT : S_FETCH);
            S_DECODE: begin
                case (bus.Opcode)
                    4'h0:                      w_next = S_MEM_RD;
                    4'h1:                      w_next = S_MEM_WR;
                    4'h2, 4'h3, 4'h4, 4'h5:    w_next = S_EXEC;
                    4'h6, 4'h7:                w_next = S_BRANCH;
                    4'h8:                      w_next = S_JUMP;
                    4'hF:                      w_next = S_HALT;
                    default:                   w_next = S_FETCH;
                endcase
            end
            S_EXEC:   w_next = S_FETCH;
            S_MEM_RD: w_next = bus.MemReady ? S_WB_ACC :
                               (w_timeout ? S_FAULT : S_MEM_RD);
            S_WB_ACC: w_next = S_FETCH;
            S_MEM_WR: w_next = bus.MemReady ? S_FETCH :
                               (w_timeout ? S_FAULT : S_MEM_WR);
            S_BRANCH: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            S_FAULT:  w_next = S_FAULT;
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait_cnt <= 8'd0;
            else if (w_waiting)
                r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    // Outputs decode from state (Mealy on MemReady in FETCH). Reset gates
    // everything to zero so no strobe leaks out during a mid-access reset.
    always_comb begin
        bus.PCWrite   = 1'b0;
        bus.Branch    = 1'b0;
        bus.bneOrbeq  = 1'b0;
        bus.PCSrc     = 2'b00;
        bus.IRWrite   = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.AccWrite  = 1'b0;
        bus.AccSrc    = 1'b0;
        bus.ALUOp     = 3'b000;
        bus.Halted    = 1'b0;
        bus.BusError  = 1'b0;
        bus.IllegalOp = 1'b0;
        bus.State     = 4'd0;
        if (!reset) begin
            bus.State = r_state;
            case (r_state)
                S_FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.IRWrite = bus.MemReady;
                    bus.PCWrite = bus.MemReady;
                end
                S_DECODE: bus.IllegalOp = (bus.Opcode >= 4'h9) && (bus.Opcode <= 4'hE);
                S_EXEC: begin
                    bus.AccWrite = 1'b1;
                    // Opcodes 2..5 map to ALU functions 0..3.
                    bus.ALUOp    = {1'b0, bus.Opcode[1:0] ^ 2'b10};
                end
                S_MEM_RD: bus.MemRead = 1'b1;
                S_WB_ACC: begin
                    bus.AccWrite = 1'b1;
                    bus.AccSrc   = 1'b1;
                end
                S_MEM_WR: bus.MemWrite = 1'b1;
                S_BRANCH: begin
                    bus.Branch   = 1'b1;
                    bus.bneOrbeq = ~bus.Opcode[0];
                    bus.PCSrc    = 2'b01;
                    bus.ALUOp    = 3'b001;
                end
                S_JUMP: begin
                    bus.PCWrite = 1'b1;
                    bus.PCSrc   = 2'b10;
                end
                S_HALT:  bus.Halted = 1'b1;
                S_FAULT: begin
                    bus.Halted   = 1'b1;
                    bus.BusError = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer (WAIT_LIMIT = 4).
//               Expected per-cycle output vectors are generated from the
//               instruction-level rules: each instruction expands into its
//               list of (state, control) cycles given its wait counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;
    string phase = "init";

    always #5 clk = ~clk;

    pc_sequencer_if bus ();

    pc_sequencer #(.WAIT_LIMIT(4)) dut (
        .CLK   (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Packed view: {State, PCWrite, Branch, bneOrbeq, PCSrc, IRWrite, MemRead,
    //               MemWrite, AccWrite, AccSrc, ALUOp, Halted, BusError, IllegalOp}
    function automatic logic [19:0] act();
        return {bus.State, bus.PCWrite, bus.Branch, bus.bneOrbeq, bus.PCSrc,
                bus.IRWrite, bus.MemRead, bus.MemWrite, bus.AccWrite, bus.AccSrc,
                bus.ALUOp, bus.Halted, bus.BusError, bus.IllegalOp};
    endfunction

    function automatic logic [19:0] mk(input int st, input int pcw, input int br,
                                       input int bq, input int pcs, input int irw,
                                       input int mrd, input int mwr, input int aw,
                                       input int as, input int alu, input int h,
                                       input int be, input int il);
        return {4'(st), 1'(pcw), 1'(br), 1'(bq), 2'(pcs), 1'(irw), 1'(mrd),
                1'(mwr), 1'(aw), 1'(as), 3'(alu), 1'(h), 1'(be), 1'(il)};
    endfunction

    function automatic logic [19:0] e_fetch(input int rdy);
        return mk(0, rdy, 0, 0, 0, rdy, 1, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [19:0] e_dec(input int il);
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, il);
    endfunction
    function automatic logic [19:0] e_exec(input int alu);
        return mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, alu, 0, 0, 0);
    endfunction
    function automatic logic [19:0] e_memrd();
        return mk(3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [19:0] e_wb();
        return mk(4, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    endfunction
    function automatic logic [19:0] e_memwr();
        return mk(5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [19:0] e_br(input int beq);
        return mk(6, 0, 1, beq, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    endfunction
    function automatic logic [19:0] e_jmp();
        return mk(7, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [19:0] e_halt();
        return mk(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    endfunction
    function automatic logic [19:0] e_fault();
        return mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    endfunction

    // One clock cycle: apply inputs, compare at the falling edge, advance.
    task automatic cyc(input logic r, input logic [3:0] op, input logic m,
                       input logic [19:0] e, input int tag);
        logic [19:0] a;
        rst          = r;
        bus.Opcode   = op;
        bus.MemReady = m;
        @(negedge clk);
        a = act();
        n_run++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s #%0d: got %05h want %05h", phase, tag, a, e);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    // Fetch with fw wait cycles, then decode of op.
    task automatic fetch_decode(input logic [3:0] op, input int fw);
        for (int i = 0; i < fw; i++) cyc(1'b0, 4'($urandom), 1'b0, e_fetch(0), i);
        cyc(1'b0, 4'($urandom), 1'b1, e_fetch(1), fw);
        cyc(1'b0, op, rnd(), e_dec((op >= 4'h9 && op <= 4'hE) ? 1 : 0), 100);
    endtask

    // Whole instruction trace derived from the opcode map and wait counts.
    task automatic run_instr(input logic [3:0] op, input int fw, input int mw);
        fetch_decode(op, fw);
        if (op >= 4'h2 && op <= 4'h5) begin
            cyc(1'b0, op, rnd(), e_exec(int'(op) - 2), 200);
        end else if (op == 4'h0) begin
            for (int i = 0; i < mw; i++) cyc(1'b0, op, 1'b0, e_memrd(), 300 + i);
            cyc(1'b0, op, 1'b1, e_memrd(), 300 + mw);
            cyc(1'b0, op, rnd(), e_wb(), 400);
        end else if (op == 4'h1) begin
            for (int i = 0; i < mw; i++) cyc(1'b0, op, 1'b0, e_memwr(), 500 + i);
            cyc(1'b0, op, 1'b1, e_memwr(), 500 + mw);
        end else if (op == 4'h6 || op == 4'h7) begin
            cyc(1'b0, op, rnd(), e_br(op == 4'h6 ? 1 : 0), 600);
        end else if (op == 4'h8) begin
            cyc(1'b0, op, rnd(), e_jmp(), 700);
        end else if (op == 4'hF) begin
            cyc(1'b0, op, rnd(), e_halt(), 800);
        end
    endtask

    typedef struct {
        logic        r;
        logic [3:0]  op;
        logic        m;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl [17];

    initial begin
        bus.Opcode   = 4'h0;
        bus.MemReady = 1'b0;

        // ADD / BNE / BEQ / JUMP / OR-with-one-wait, all back to back.
        tbl[0]  = '{1'b1, 4'h0, 1'b0, 20'h0};
        tbl[1]  = '{1'b0, 4'h2, 1'b1, e_fetch(1)};
        tbl[2]  = '{1'b0, 4'h2, 1'b1, e_dec(0)};
        tbl[3]  = '{1'b0, 4'h2, 1'b1, e_exec(0)};
        tbl[4]  = '{1'b0, 4'h7, 1'b1, e_fetch(1)};
        tbl[5]  = '{1'b0, 4'h7, 1'b0, e_dec(0)};
        tbl[6]  = '{1'b0, 4'h7, 1'b0, e_br(0)};
        tbl[7]  = '{1'b0, 4'h6, 1'b1, e_fetch(1)};
        tbl[8]  = '{1'b0, 4'h6, 1'b1, e_dec(0)};
        tbl[9]  = '{1'b0, 4'h6, 1'b1, e_br(1)};
        tbl[10] = '{1'b0, 4'h8, 1'b1, e_fetch(1)};
        tbl[11] = '{1'b0, 4'h8, 1'b0, e_dec(0)};
        tbl[12] = '{1'b0, 4'h8, 1'b1, e_jmp()};
        tbl[13] = '{1'b0, 4'h5, 1'b0, e_fetch(0)};
        tbl[14] = '{1'b0, 4'h5, 1'b1, e_fetch(1)};
        tbl[15] = '{1'b0, 4'h5, 1'b1, e_dec(0)};
        tbl[16] = '{1'b0, 4'h5, 1'b0, e_exec(3)};

        phase = "table";
        for (int i = 0; i < 17; i++) cyc(tbl[i].r, tbl[i].op, tbl[i].m, tbl[i].exp, i);

        phase = "load_wait";
        run_instr(4'h0, 0, 3);

        phase = "illegal";
        run_instr(4'hB, 0, 0);
        cyc(1'b0, 4'h0, 1'b0, e_fetch(0), 0);

        phase = "halt";
        cyc(1'b1, 4'h0, 1'b0, 20'h0, 0);
        run_instr(4'hF, 0, 0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 4'($urandom), rnd(), e_halt(), i);
        cyc(1'b1, 4'h0, 1'b1, 20'h0, 50);
        cyc(1'b0, 4'h0, 1'b0, e_fetch(0), 51);

        phase = "timeout_fetch";
        cyc(1'b1, 4'h0, 1'b0, 20'h0, 0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'h2, 1'b0, e_fetch(0), i);
        for (int i = 0; i < 5; i++) cyc(1'b0, 4'($urandom), rnd(), e_fault(), 10 + i);

        phase = "limit_ready";
        cyc(1'b1, 4'h0, 1'b0, 20'h0, 0);
        run_instr(4'h2, 3, 0);
        run_instr(4'h0, 3, 3);

        phase = "timeout_memwr";
        fetch_decode(4'h1, 0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'h1, 1'b0, e_memwr(), i);
        cyc(1'b0, 4'h1, 1'b1, e_fault(), 10);

        phase = "reset_memwr";
        cyc(1'b1, 4'h0, 1'b0, 20'h0, 0);
        fetch_decode(4'h1, 1);
        cyc(1'b0, 4'h1, 1'b0, e_memwr(), 1);
        cyc(1'b1, 4'h1, 1'b0, 20'h0, 2);
        cyc(1'b0, 4'h1, 1'b0, e_fetch(0), 3);

        phase = "random";
        cyc(1'b1, 4'h0, 1'b0, 20'h0, 0);
        for (int n = 0; n < 250; n++)
            run_instr(4'($urandom_range(0, 14)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
